mem_wb_multi: RTL and testbench

Parametrised MEM/WB pipeline register for multi-issue configurations of the core. It captures one bundle of `LANES` memory-stage results per clock and presents them to the register-file and HI/LO write ports. It adds four things:
- a flush input;
- same-bundle write-conflict resolution;
- `$0` write suppression;
- saturating retire and bubble counters for performance monitoring.

It sits between the MEM stage and the register file / hilo_reg, under control of the global stall controller.

---
 rtl/mem_wb_multi.sv | 136 +++++++++++++
 tb/tb_mem_wb_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for a multi-issue core: captures one bundle of LANES results,
// resolves same-bundle write conflicts and $0 writes, and keeps saturating retire/bubble counters.
module mem_wb_multi #(
  parameter int LANES         = 2,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int STALL_W       = 6,
  parameter int STAGE         = 4,
  parameter int CNT_W         = 32,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     cnt_clr,
  input  logic [LANES-1:0]         mem_valid,
  input  logic [LANES-1:0]         mem_wReg,
  input  logic [LANES*ADDR_W-1:0]  mem_wAddr,
  input  logic [LANES*DATA_W-1:0]  mem_wData,
  input  logic                     mem_wHiLo,
  input  logic [DATA_W-1:0]        mem_hiData,
  input  logic [DATA_W-1:0]        mem_loData,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_wReg,
  output logic [LANES*ADDR_W-1:0]  wb_wAddr,
  output logic [LANES*DATA_W-1:0]  wb_wData,
  output logic                     wb_wHiLo,
  output logic [DATA_W-1:0]        wb_hiData,
  output logic [DATA_W-1:0]        wb_loData,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic [LANES-1:0]        r_valid;
  logic [LANES-1:0]        r_wreg;
  logic [LANES*ADDR_W-1:0] r_waddr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic                    r_whilo;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;
  logic [CNT_W-1:0]        r_retire_cnt;
  logic [CNT_W-1:0]        r_bubble_cnt;

  logic [LANES-1:0] w_wr_req;
  logic [LANES-1:0] w_wreg_res;
  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_retire_sum;
  logic [CNT_W:0]   w_bubble_sum;
  logic             w_capture;
  logic             w_bubble;
  logic             w_stall_unused;

  // Only this stage's bit and the downstream bit matter here.
  assign w_stall_unused = ^stall;

  assign w_capture = !flush && !stall[STAGE];
  assign w_bubble  = flush || (stall[STAGE] && !stall[STAGE+1]);
  assign w_wr_req  = mem_valid & mem_wReg;

  // Later lanes are later in program order, so an earlier lane loses to any later writer of the same register.
  // NOTE: every always_comb output gets a default before conditional updates so no latch is inferred.
  always_comb begin
    w_wreg_res = w_wr_req;
    for (int i = 0; i < LANES; i++) begin
      if (ZERO_SUPPRESS && (mem_wAddr[i*ADDR_W +: ADDR_W] == '0)) w_wreg_res[i] = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wr_req[j] && (mem_wAddr[j*ADDR_W +: ADDR_W] == mem_wAddr[i*ADDR_W +: ADDR_W]))
          w_wreg_res[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) w_pop = w_pop + {{CNT_W{1'b0}}, mem_valid[i]};
  end

  // One extra bit catches the overflow; a set carry means clamp to all-ones.
  assign w_retire_sum = {1'b0, r_retire_cnt} + w_pop;
  assign w_bubble_sum = {1'b0, r_bubble_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= '0;
      r_wreg       <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_whilo      <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_valid <= mem_valid;
        r_wreg  <= w_wreg_res;
        r_waddr <= mem_wAddr;
        r_wdata <= mem_wData;
        r_whilo <= mem_wHiLo & (|mem_valid);
        r_hi    <= mem_hiData;
        r_lo    <= mem_loData;
      end else if (w_bubble) begin
        r_valid <= '0;
        r_wreg  <= '0;
        r_waddr <= '0;
        r_wdata <= '0;
        r_whilo <= 1'b0;
        r_hi    <= '0;
        r_lo    <= '0;
      end

      if (cnt_clr) begin
        r_retire_cnt <= '0;
        r_bubble_cnt <= '0;
      end else begin
        if (w_capture)
          r_retire_cnt <= w_retire_sum[CNT_W] ? '1 : w_retire_sum[CNT_W-1:0];
        if (w_bubble)
          r_bubble_cnt <= w_bubble_sum[CNT_W] ? '1 : w_bubble_sum[CNT_W-1:0];
      end
    end
  end

  assign wb_valid   = r_valid;
  assign wb_wReg    = r_wreg;
  assign wb_wAddr   = r_waddr;
  assign wb_wData   = r_wdata;
  assign wb_wHiLo   = r_whilo;
  assign wb_hiData  = r_hi;
  assign wb_loData  = r_lo;
  assign retire_cnt = r_retire_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Bench for mem_wb_multi (2 lanes, 4-bit counters): directed vector table, counter
// saturation sequence, then random traffic against a behavioural model.
module tb_mem_wb_multi;

  localparam int LANES = 2, DATA_W = 32, ADDR_W = 5, STALL_W = 6, STAGE = 4, CNT_W = 4;
  localparam int CNT_MAX = 15;

  typedef struct {
    logic        rst, flush, clr;
    logic [5:0]  stall;
    logic [1:0]  valid, wreg;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        hilo;
    logic [31:0] hi, lo;
  } in_t;

  typedef struct {
    logic [1:0]  valid, wreg;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        hilo;
    logic [31:0] hi, lo;
    int          ret, bub;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  e;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst, flush, cnt_clr;
  logic [STALL_W-1:0]      stall;
  logic [LANES-1:0]        mem_valid, mem_wReg;
  logic [LANES*ADDR_W-1:0] mem_wAddr;
  logic [LANES*DATA_W-1:0] mem_wData;
  logic                    mem_wHiLo;
  logic [DATA_W-1:0]       mem_hiData, mem_loData;
  logic [LANES-1:0]        wb_valid, wb_wReg;
  logic [LANES*ADDR_W-1:0] wb_wAddr;
  logic [LANES*DATA_W-1:0] wb_wData;
  logic                    wb_wHiLo;
  logic [DATA_W-1:0]       wb_hiData, wb_loData;
  logic [CNT_W-1:0]        retire_cnt, bubble_cnt;

  int checks = 0;
  int failures = 0;

  mem_wb_multi #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
    .STAGE(STAGE), .CNT_W(CNT_W), .ZERO_SUPPRESS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wReg(mem_wReg), .mem_wAddr(mem_wAddr),
    .mem_wData(mem_wData), .mem_wHiLo(mem_wHiLo), .mem_hiData(mem_hiData),
    .mem_loData(mem_loData), .wb_valid(wb_valid), .wb_wReg(wb_wReg),
    .wb_wAddr(wb_wAddr), .wb_wData(wb_wData), .wb_wHiLo(wb_wHiLo),
    .wb_hiData(wb_hiData), .wb_loData(wb_loData), .retire_cnt(retire_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t zeros(input int ret, input int bub);
    exp_t e;
    e = '{2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, ret, bub};
    return e;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  // Expected state after one edge, from the operating rules.
  function automatic exp_t model(input exp_t cur, input in_t in);
    exp_t n;
    int   owner[32];
    int   addr[2];
    logic cap, bub;
    n = cur;
    if (!in.rst) return zeros(0, 0);
    cap = !in.flush && !in.stall[4];
    bub = in.flush || (in.stall[4] && !in.stall[5]);
    if (cap) begin
      addr[0] = int'(in.a0);
      addr[1] = int'(in.a1);
      for (int a = 0; a < 32; a++) owner[a] = -1;
      for (int l = 0; l < 2; l++)
        if (in.valid[l] && in.wreg[l]) owner[addr[l]] = l;
      n.valid = in.valid;
      for (int l = 0; l < 2; l++) n.wreg[l] = (owner[addr[l]] == l) && (addr[l] != 0);
      n.a0 = in.a0; n.a1 = in.a1; n.d0 = in.d0; n.d1 = in.d1;
      n.hilo = in.hilo && (in.valid != 2'b00);
      n.hi = in.hi; n.lo = in.lo;
    end else if (bub) begin
      n = zeros(cur.ret, cur.bub);
    end
    if (in.clr) begin
      n.ret = 0;
      n.bub = 0;
    end else begin
      if (cap) n.ret = sat_add(cur.ret, $countones(in.valid));
      if (bub) n.bub = sat_add(cur.bub, 1);
    end
    return n;
  endfunction

  task automatic apply(input in_t in);
    rst        = in.rst;
    flush      = in.flush;
    cnt_clr    = in.clr;
    stall      = in.stall;
    mem_valid  = in.valid;
    mem_wReg   = in.wreg;
    mem_wAddr  = {in.a1, in.a0};
    mem_wData  = {in.d1, in.d0};
    mem_wHiLo  = in.hilo;
    mem_hiData = in.hi;
    mem_loData = in.lo;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".wb_valid"},   64'(wb_valid),       64'(e.valid));
    check({tag, ".wb_wReg"},    64'(wb_wReg),        64'(e.wreg));
    check({tag, ".wb_wAddr0"},  64'(wb_wAddr[4:0]),  64'(e.a0));
    check({tag, ".wb_wAddr1"},  64'(wb_wAddr[9:5]),  64'(e.a1));
    check({tag, ".wb_wData0"},  64'(wb_wData[31:0]), 64'(e.d0));
    check({tag, ".wb_wData1"},  64'(wb_wData[63:32]),64'(e.d1));
    check({tag, ".wb_wHiLo"},   64'(wb_wHiLo),       64'(e.hilo));
    check({tag, ".wb_hiData"},  64'(wb_hiData),      64'(e.hi));
    check({tag, ".wb_loData"},  64'(wb_loData),      64'(e.lo));
    check({tag, ".retire_cnt"}, 64'(retire_cnt),     64'(e.ret));
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt),     64'(e.bub));
  endtask

  vec_t vecs[$];
  in_t  in;
  exp_t m;

  initial begin
    // in_t: rst, flush, clr, stall, valid, wreg, a0, a1, d0, d1, hilo, hi, lo
    // exp_t: valid, wreg, a0, a1, d0, d1, hilo, hi, lo, ret, bub
    vecs.push_back('{"reset0", '{1'b0, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'd3, 5'd7, 32'h1111, 32'h2222, 1'b1, 32'hAAAA, 32'hBBBB}, zeros(0, 0)});
    vecs.push_back('{"reset1", '{1'b0, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'd3, 5'd7, 32'h1111, 32'h2222, 1'b1, 32'hAAAA, 32'hBBBB}, zeros(0, 0)});
    vecs.push_back('{"capture", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'd3, 5'd7, 32'h1111, 32'h2222, 1'b1, 32'hAAAA, 32'hBBBB},
                     '{2'b11, 2'b11, 5'd3, 5'd7, 32'h1111, 32'h2222, 1'b1, 32'hAAAA, 32'hBBBB, 2, 0}});
    vecs.push_back('{"conflict", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 1'b0, 32'hC0, 32'hC1},
                     '{2'b11, 2'b10, 5'd5, 5'd5, 32'hA, 32'hB, 1'b0, 32'hC0, 32'hC1, 4, 0}});
    vecs.push_back('{"conflict_l1_invalid", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b01, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 1'b0, 32'hC0, 32'hC1},
                     '{2'b01, 2'b01, 5'd5, 5'd5, 32'hA, 32'hB, 1'b0, 32'hC0, 32'hC1, 5, 0}});
    vecs.push_back('{"zero_suppress", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b01, 2'b01, 5'd0, 5'd9, 32'hFFFF, 32'h1234, 1'b1, 32'hD0, 32'hD1},
                     '{2'b01, 2'b00, 5'd0, 5'd9, 32'hFFFF, 32'h1234, 1'b1, 32'hD0, 32'hD1, 6, 0}});
    vecs.push_back('{"bubble0", '{1'b1, 1'b0, 1'b0, 6'b011111, 2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1}, zeros(6, 1)});
    vecs.push_back('{"bubble1", '{1'b1, 1'b0, 1'b0, 6'b011111, 2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1}, zeros(6, 2)});
    vecs.push_back('{"recapture", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1},
                     '{2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1, 8, 2}});
    vecs.push_back('{"hold0", '{1'b1, 1'b0, 1'b0, 6'b111111, 2'b11, 2'b11, 5'd8, 5'd9, 32'h77, 32'h88, 1'b0, 32'hF0, 32'hF1},
                     '{2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1, 8, 2}});
    vecs.push_back('{"hold1", '{1'b1, 1'b0, 1'b0, 6'b111111, 2'b11, 2'b11, 5'd8, 5'd9, 32'h77, 32'h88, 1'b0, 32'hF0, 32'hF1},
                     '{2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 1'b1, 32'hE0, 32'hE1, 8, 2}});
    vecs.push_back('{"flush_over_stall", '{1'b1, 1'b1, 1'b0, 6'b111111, 2'b11, 2'b11, 5'd8, 5'd9, 32'h77, 32'h88, 1'b1, 32'hF0, 32'hF1}, zeros(8, 3)});
    vecs.push_back('{"hilo_no_valid", '{1'b1, 1'b0, 1'b0, 6'h00, 2'b00, 2'b11, 5'd4, 5'd4, 32'h44, 32'h45, 1'b1, 32'h46, 32'h47},
                     '{2'b00, 2'b00, 5'd4, 5'd4, 32'h44, 32'h45, 1'b0, 32'h46, 32'h47, 8, 3}});
    vecs.push_back('{"clr_with_capture", '{1'b1, 1'b0, 1'b1, 6'h00, 2'b11, 2'b11, 5'd6, 5'd7, 32'h66, 32'h67, 1'b0, 32'h0, 32'h0},
                     '{2'b11, 2'b11, 5'd6, 5'd7, 32'h66, 32'h67, 1'b0, 32'h0, 32'h0, 0, 0}});
    vecs.push_back('{"flush_no_stall", '{1'b1, 1'b1, 1'b0, 6'h00, 2'b11, 2'b11, 5'd6, 5'd7, 32'h66, 32'h67, 1'b1, 32'h1, 32'h2}, zeros(0, 1)});
    vecs.push_back('{"reset_while_hold", '{1'b0, 1'b0, 1'b0, 6'b111111, 2'b11, 2'b11, 5'd6, 5'd7, 32'h66, 32'h67, 1'b1, 32'h1, 32'h2}, zeros(0, 0)});

    #2;
    foreach (vecs[k]) begin
      apply(vecs[k].in);
      compare(vecs[k].name, vecs[k].e);
    end

    // Retire counter saturates at 15 with two retirements per cycle.
    for (int k = 1; k <= 10; k++) begin
      in = '{1'b1, 1'b0, 1'b0, 6'h00, 2'b11, 2'b11, 5'(k), 5'(k + 10), 32'(k), 32'(k + 100), 1'b0, 32'h0, 32'h0};
      apply(in);
      check($sformatf("sat_retire_%0d", k), 64'(retire_cnt), 64'((2 * k > CNT_MAX) ? CNT_MAX : 2 * k));
    end
    for (int k = 1; k <= 20; k++) begin
      in = '{1'b1, 1'b0, 1'b0, 6'b011111, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};
      apply(in);
    end
    check("sat_bubble", 64'(bubble_cnt), 64'(CNT_MAX));
    check("sat_retire_frozen_by_bubble", 64'(retire_cnt), 64'(CNT_MAX));
    in = '{1'b1, 1'b0, 1'b1, 6'h00, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};
    apply(in);
    check("clr_after_sat_retire", 64'(retire_cnt), 64'd0);
    check("clr_after_sat_bubble", 64'(bubble_cnt), 64'd0);
    check("clr_after_sat_wreg", 64'(wb_wReg), 64'b11);

    // Random traffic; the first cycle resets so the model starts in a known state.
    m = zeros(0, 0);
    for (int k = 0; k < 400; k++) begin
      int mode;
      in.rst   = (k == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      in.flush = ($urandom_range(0, 7) == 0);
      in.clr   = ($urandom_range(0, 24) == 0);
      in.stall = 6'($urandom);
      mode = $urandom_range(0, 3);
      if (mode <= 1) in.stall[4] = 1'b0;
      else if (mode == 2) begin in.stall[4] = 1'b1; in.stall[5] = 1'b0; end
      else begin in.stall[4] = 1'b1; in.stall[5] = 1'b1; end
      in.valid = 2'($urandom);
      in.wreg  = 2'($urandom);
      in.a0    = 5'($urandom_range(0, 3));
      in.a1    = 5'($urandom_range(0, 3));
      in.d0    = $urandom;
      in.d1    = $urandom;
      in.hilo  = 1'($urandom);
      in.hi    = $urandom;
      in.lo    = $urandom;
      m = model(m, in);
      apply(in);
      compare($sformatf("rand%0d", k), m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
